// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the parametrised program memory.
package prog_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int unsigned WIDTH_DEF = 26;
  localparam int unsigned DEPTH_DEF = 10;

  // Smallest pointer width able to address every word; never below one bit.
  function automatic int unsigned min_ptr_w(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Plain DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Out-of-range addresses read as zero rather than indexing past the array.
  assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/prog_mem.sv
// Program memory top: post-reset clear sequence, range check, write lock,
// write-first read mux and registered read/status outputs.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] pointer,
  input  logic             write_data,
  input  logic             read_data,
  input  logic [WIDTH-1:0] data_to_write,
  input  logic             lock,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic             addr_error,
  output logic             wr_blocked
);

  if (PTR_W < min_ptr_w(DEPTH)) begin : g_bad_ptr_w
    $error("prog_mem: PTR_W too small for DEPTH");
  end

  localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             addr_error_q, addr_error_d;
  logic             wr_blocked_q, wr_blocked_d;

  logic             arr_we;
  logic [PTR_W-1:0] arr_waddr;
  logic [WIDTH-1:0] arr_wdata;
  logic [WIDTH-1:0] arr_rdata;
  logic             in_range;
  logic             wr_ok;

  assign in_range = (32'(pointer) < DEPTH);

  prog_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (pointer),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      addr_error_q <= 1'b0;
      wr_blocked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      addr_error_q <= addr_error_d;
      wr_blocked_q <= wr_blocked_d;
    end
  end

  // Next state, array write port steering and registered output values.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    addr_error_d = 1'b0;
    wr_blocked_d = 1'b0;
    arr_we       = 1'b0;
    arr_waddr    = pointer;
    arr_wdata    = data_to_write;
    wr_ok        = 1'b0;

    if (state_q == CLEAR) begin
      // Strobes are dropped while the array is being zeroed.
      arr_we    = 1'b1;
      arr_waddr = clr_cnt_q;
      arr_wdata = '0;
      if (clr_cnt_q == LAST_WORD) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = PTR_W'(clr_cnt_q + 1'b1);
      end
    end else begin
      wr_ok        = write_data & in_range & ~lock;
      arr_we       = wr_ok;
      addr_error_d = (write_data | read_data) & ~in_range;
      wr_blocked_d = write_data & in_range & lock;
      if (read_data) begin
        data_valid_d = 1'b1;
        if (!in_range) begin
          data_d = '0;
        end else if (wr_ok) begin
          data_d = data_to_write;
        end else begin
          data_d = arr_rdata;
        end
      end
    end

    busy_d = (state_d == CLEAR);
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign addr_error = addr_error_q;
  assign wr_blocked = wr_blocked_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: a behavioural model pushes expected outputs to a
// scoreboard queue as each cycle is driven; they are popped and asserted after the edge.
module tb_prog_mem;

  localparam int unsigned W = 26;
  localparam int unsigned D = 10;
  localparam int unsigned P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [P-1:0] pointer;
  logic         write_data;
  logic         read_data;
  logic [W-1:0] data_to_write;
  logic         lock;
  logic [W-1:0] data;
  logic         data_valid;
  logic         busy;
  logic         addr_error;
  logic         wr_blocked;

  always #5 clk = ~clk;

  prog_mem #(.WIDTH(W), .DEPTH(D), .PTR_W(P)) dut (
    .clk           (clk),
    .reset         (reset),
    .pointer       (pointer),
    .write_data    (write_data),
    .read_data     (read_data),
    .data_to_write (data_to_write),
    .lock          (lock),
    .data          (data),
    .data_valid    (data_valid),
    .busy          (busy),
    .addr_error    (addr_error),
    .wr_blocked    (wr_blocked)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         dv;
    logic         ae;
    logic         wb;
    logic         busy;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_mem [D];
  int           m_clr;
  logic         m_busy;
  logic [W-1:0] m_data;
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the outputs after the edge, then compare.
  task automatic cyc(input logic rst_v, input logic wr, input logic rd, input logic lk,
                     input int ptr, input logic [W-1:0] wd);
    exp_t e;
    logic inr;
    @(negedge clk);
    reset         = rst_v;
    write_data    = wr;
    read_data     = rd;
    lock          = lk;
    pointer       = P'(ptr);
    data_to_write = wd;
    inr    = (ptr < int'(D));
    e.dv   = 1'b0;
    e.ae   = 1'b0;
    e.wb   = 1'b0;
    if (rst_v) begin
      m_clr  = 0;
      m_busy = 1'b1;
      m_data = '0;
    end else if (m_busy) begin
      m_mem[m_clr] = '0;
      m_clr++;
      if (m_clr == int'(D)) m_busy = 1'b0;
    end else begin
      if (rd) begin
        e.dv = 1'b1;
        if (!inr)              m_data = '0;
        else if (wr && !lk)    m_data = wd;
        else                   m_data = m_mem[ptr];
      end
      if (wr && inr && !lk) m_mem[ptr] = wd;
      e.ae = (wr || rd) && !inr;
      e.wb = wr && inr && lk;
    end
    e.data = m_data;
    e.busy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("data p%0d", ptr),       data,              e.data);
    chk($sformatf("data_valid p%0d", ptr), W'(data_valid),    W'(e.dv));
    chk($sformatf("addr_error p%0d", ptr), W'(addr_error),    W'(e.ae));
    chk($sformatf("wr_blocked p%0d", ptr), W'(wr_blocked),    W'(e.wb));
    chk("busy",                            W'(busy),          W'(e.busy));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic rd(input int ptr);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, ptr, '0);
  endtask

  task automatic wr(input int ptr, input logic [W-1:0] v, input logic lk);
    cyc(1'b0, 1'b1, 1'b0, lk, ptr, v);
  endtask

  initial begin
    reset = 1'b1; write_data = 1'b0; read_data = 1'b0; lock = 1'b0;
    pointer = '0; data_to_write = '0;
    for (int i = 0; i < int'(D); i++) m_mem[i] = 'x;
    m_clr = 0; m_busy = 1'b1; m_data = '0;

    // Reset pulse, then ten clear cycles with busy high, then all words read zero.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    for (int i = 0; i < int'(D); i++) idle();
    for (int i = 0; i < int'(D); i++) rd(i);
    idle();

    // Write then read back; neighbour stays zero.
    wr(3, 26'h3ABCDEF, 1'b0);
    rd(3);
    rd(4);

    // Same-cycle read and write: write-first.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 7, 26'h155);
    idle();
    rd(7);

    // Locked write is refused; locked read+write returns the stored word.
    wr(2, 26'h1, 1'b1);
    rd(2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 3, 26'h0000AAA);

    // Out-of-range write, read, both, and locked write.
    wr(12, 26'h2222222, 1'b0);
    rd(12);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 15, 26'h1234567);
    wr(10, 26'h1111111, 1'b1);
    for (int i = 0; i < int'(D); i++) rd(i);

    // Preload distinct words, reset mid-clear, strobes during clear are ignored.
    for (int i = 0; i < int'(D); i++) wr(i, W'(32'h100 + i * 3), 1'b0);
    rd(9);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5, 26'h3FFFFFF);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, i, 26'h0F0F0F0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    for (int i = 0; i < int'(D); i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, (i * 7) % 16, 26'h3C3C3C3);
    for (int i = 0; i < int'(D); i++) rd(i);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
